mul_div_unit: RTL

- Iterative multi-cycle multiply/divide unit for the RV32M extension.
- Sits beside the single-cycle ALU in the execute stage. The control unit issues an operation with a start pulse and stalls the pipeline while busy is high.
- Radix-2: one partial product or one quotient bit per cycle. Latency is fixed and independent of operand values.

---
 rtl/mul_div_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: one product or quotient bit per
// cycle, fixed latency, sign handled by magnitude arithmetic plus a final fix-up.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] srcA,
  input  logic [DATA_WIDTH-1:0] srcB,
  input  logic [2:0]            mdControl,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] mdResult
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                  state, next_state;
  logic [2:0]              op;
  logic [DATA_WIDTH-1:0]   a_raw, a_mag, b_mag;
  logic                    sign_a, sign_b;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0]    counter;

  logic                    signed_a, signed_b, neg_a, neg_b;
  logic [DATA_WIDTH:0]     mul_sum, div_trial, div_diff;
  logic                    div_ge, b_zero;
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0]   quot_fix, rem_fix, fix_result;

  assign signed_a = mdControl inside {3'b001, 3'b010, 3'b100, 3'b110};
  assign signed_b = mdControl inside {3'b001, 3'b100, 3'b110};
  assign neg_a    = signed_a & srcA[DATA_WIDTH-1];
  assign neg_b    = signed_b & srcB[DATA_WIDTH-1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start) next_state = CALC;
      CALC: if (counter == CNT_WIDTH'(DATA_WIDTH - 1)) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // acc serves both operations: multiply keeps {partial sum, multiplier},
  // divide keeps {partial remainder, dividend/quotient shift register}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    div_trial = acc[2*DATA_WIDTH-1:DATA_WIDTH-1];
    div_diff  = div_trial - {1'b0, b_mag};
    div_ge    = (div_trial >= {1'b0, b_mag});
  end

  always_comb begin
    b_zero   = (b_mag == '0);
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quot_fix = b_zero ? '1 :
               ((sign_a ^ sign_b) ? -acc[DATA_WIDTH-1:0] : acc[DATA_WIDTH-1:0]);
    rem_fix  = b_zero ? a_raw :
               (sign_a ? -acc[2*DATA_WIDTH-1:DATA_WIDTH] : acc[2*DATA_WIDTH-1:DATA_WIDTH]);
    unique case (op)
      3'b000:                 fix_result = prod_fix[DATA_WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      3'b100, 3'b101:         fix_result = quot_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op       <= '0;
      a_raw    <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      acc      <= '0;
      counter  <= '0;
      mdResult <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          op      <= mdControl;
          a_raw   <= srcA;
          a_mag   <= neg_a ? -srcA : srcA;
          b_mag   <= neg_b ? -srcB : srcB;
          sign_a  <= neg_a;
          sign_b  <= neg_b;
          counter <= '0;
          acc     <= {{DATA_WIDTH{1'b0}},
                      mdControl[2] ? (neg_a ? -srcA : srcA) : (neg_b ? -srcB : srcB)};
        end
        CALC: begin
          counter <= counter + 1'b1;
          if (op[2])
            acc <= {div_ge ? div_diff[DATA_WIDTH-1:0] : div_trial[DATA_WIDTH-1:0],
                    acc[DATA_WIDTH-2:0], div_ge};
          else
            acc <= {mul_sum, acc[DATA_WIDTH-1:1]};
        end
        FIX:  mdResult <= fix_result;
        default: ;
      endcase
    end
  end

endmodule
